audiodac_dsdemod: RTL and testbench

Delta-sigma demodulator: the receive-side counterpart of the audio DAC modulator. Decimates a 1-bit delta-sigma stream (the DAC `ds_o`, looped back or taken from a pad) through a 3rd-order CIC filter into 16-bit signed PCM samples. Results are offered over the same `rdy`/`ack` sample handshake the DAC FIFO uses, with this block as the transmitting side. Used for on-chip loopback self-test and for characterising modulator output without external equipment.

---
 rtl/dsdemod_pkg.sv | 31 +++
 rtl/dsdemod_cic.sv | 106 ++++++++++
 rtl/audiodac_dsdemod.sv | 106 ++++++++++
 tb/tb_audiodac_dsdemod.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsdemod_pkg.sv
// Shared constants and OSR-code helpers for the delta-sigma demodulator.
package dsdemod_pkg;

    localparam int CIC_ORDER = 3;
    localparam int ACC_W     = 26;
    localparam int OUT_W     = 16;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        OSR_32  = 2'd0,
        OSR_64  = 2'd1,
        OSR_128 = 2'd2,
        OSR_256 = 2'd3
    } osr_e;

    typedef logic signed [ACC_W-1:0] acc_t;

    // k = log2(R); codes map to R = 32, 64, 128, 256.
    function automatic int unsigned osr_log2(osr_e code);
        return 32'd5 + 32'(code);
    endfunction

    function automatic logic [CNT_W-1:0] osr_last(osr_e code);
        return CNT_W'((32'd1 << osr_log2(code)) - 32'd1);
    endfunction

    function automatic int unsigned osr_shift(osr_e code);
        return CIC_ORDER * osr_log2(code) - (OUT_W - 1);
    endfunction

endpackage

// File: rtl/dsdemod_cic.sv
// Third-order CIC decimator: integrators, decimation counter, combs, scaling and
// saturation to a 16-bit sample with a one-cycle valid.
module dsdemod_cic
    import dsdemod_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  osr_e             osr_i,
    input  logic             ds_i,
    output logic             smp_vld_o,
    output logic [OUT_W-1:0] smp_o
);

    localparam acc_t             SAT_HI   = acc_t'(2 ** (OUT_W - 1) - 1);
    localparam acc_t             SAT_LO   = acc_t'(-(2 ** (OUT_W - 1)));
    localparam logic [OUT_W-1:0] MAX_CODE = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_CODE = {1'b1, {(OUT_W - 1){1'b0}}};

    acc_t             int_q [CIC_ORDER];
    acc_t             int_d [CIC_ORDER];
    acc_t             dly_q [CIC_ORDER];
    acc_t             dly_d [CIC_ORDER];
    acc_t             comb_q, comb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic             strobe;
    acc_t             x;
    acc_t             carry;
    acc_t             diff;
    acc_t             scaled;

    assign x = ds_i ? acc_t'(1) : acc_t'(-1);

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        cnt_d  = cnt_q;
        comb_d = comb_q;
        vld_d  = 1'b0;
        carry  = x;
        for (int i = 0; i < CIC_ORDER; i++) begin
            dly_d[i] = dly_q[i];
            int_d[i] = int_q[i] + carry;
            carry    = int_d[i];
        end

        // Decimate the freshly updated last integrator, then run the combs.
        diff   = carry;
        strobe = (cnt_q == osr_last(osr_i));
        if (strobe) begin
            for (int i = 0; i < CIC_ORDER; i++) begin
                dly_d[i] = diff;
                diff     = diff - dly_q[i];
            end
            comb_d = diff;
            vld_d  = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (!en_i) begin
            for (int i = 0; i < CIC_ORDER; i++) begin
                int_d[i] = '0;
                dly_d[i] = '0;
            end
            comb_d = '0;
            vld_d  = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: filter state is a handful of flops, not a RAM, so it is reset like any register.
            for (int i = 0; i < CIC_ORDER; i++) begin
                int_q[i] <= '0;
                dly_q[i] <= '0;
            end
            comb_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            int_q  <= int_d;
            dly_q  <= dly_d;
            comb_q <= comb_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    always_comb begin
        scaled = comb_q >>> osr_shift(osr_i);
        if (scaled > SAT_HI) begin
            smp_o = MAX_CODE;
        end else if (scaled < SAT_LO) begin
            smp_o = MIN_CODE;
        end else begin
            smp_o = scaled[OUT_W-1:0];
        end
    end

    assign smp_vld_o = vld_q;

endmodule

// File: rtl/audiodac_dsdemod.sv
// Delta-sigma demodulator top: OSR latch, optional input synchronizer
// (DSDEMOD_INPUT_SYNC_EN), output sample register, rdy/ack handshake and overrun flag.
module audiodac_dsdemod #(
    parameter int OUT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [1:0]       osr_i,
    input  logic             ds_i,
    output logic [OUT_W-1:0] sample_o,
    output logic             sample_rdy_o,
    input  logic             sample_ack_i,
    output logic             overrun_o
);

    import dsdemod_pkg::osr_e;
    import dsdemod_pkg::OSR_32;

    logic             en_prev_q;
    osr_e             osr_q, osr_d;
    logic [OUT_W-1:0] sample_q, sample_d;
    logic             rdy_q, rdy_d;
    logic             ovr_q, ovr_d;

    logic             cic_en;
    logic             cic_ds;
    osr_e             cic_osr;
    logic             cic_vld;
    logic [OUT_W-1:0] cic_smp;

    // The ratio is captured only on the enable rising edge and used in that same cycle.
    assign osr_d = (en_i && !en_prev_q) ? osr_e'(osr_i) : osr_q;

`ifdef DSDEMOD_INPUT_SYNC_EN
    logic [1:0] ds_sync_q;
    logic [1:0] en_sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ds_sync_q <= '0;
            en_sync_q <= '0;
        end else begin
            ds_sync_q <= {ds_sync_q[0], ds_i};
            en_sync_q <= {en_sync_q[0], en_i};
        end
    end

    assign cic_ds  = ds_sync_q[1];
    assign cic_en  = en_sync_q[1];
    assign cic_osr = osr_q;
`else
    assign cic_ds  = ds_i;
    assign cic_en  = en_i;
    assign cic_osr = osr_d;
`endif

    dsdemod_cic u_cic (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (cic_en),
        .osr_i     (cic_osr),
        .ds_i      (cic_ds),
        .smp_vld_o (cic_vld),
        .smp_o     (cic_smp)
    );

    always_comb begin
        sample_d = sample_q;
        rdy_d    = rdy_q;
        ovr_d    = ovr_q;
        if (rdy_q && sample_ack_i) begin
            rdy_d = 1'b0;
        end
        // A same-cycle ack frees the slot, so the new sample loads instead of overrunning.
        if (cic_vld) begin
            if (!rdy_q || sample_ack_i) begin
                sample_d = cic_smp;
                rdy_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_prev_q <= 1'b0;
            osr_q     <= OSR_32;
            sample_q  <= '0;
            rdy_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            en_prev_q <= en_i;
            osr_q     <= osr_d;
            sample_q  <= sample_d;
            rdy_q     <= rdy_d;
            ovr_q     <= ovr_d;
        end
    end

    assign sample_o     = sample_q;
    assign sample_rdy_o = rdy_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_audiodac_dsdemod.sv
// Self-checking bench for audiodac_dsdemod: directed scenarios with random streams,
// checked against a box^3 impulse-response model of the CIC.
module tb_audiodac_dsdemod;

`ifdef DSDEMOD_INPUT_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        clk_i        = 1'b0;
    logic        rst_n_i      = 1'b0;
    logic        en_i         = 1'b0;
    logic [1:0]  osr_i        = 2'd0;
    logic        ds_i         = 1'b0;
    logic        sample_ack_i = 1'b0;
    logic [15:0] sample_o;
    logic        sample_rdy_o;
    logic        overrun_o;

    int          errors = 0;
    int          checks = 0;

    int          xs[$];
    int          h[$];
    int          cnt;
    int          R;
    int          mode;
    bit          auto_ack;
    bit          rdy_prev;
    int          steady;
    logic [15:0] steady_val;
    logic [15:0] held;

    audiodac_dsdemod #(.OUT_W(16)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (en_i),
        .osr_i        (osr_i),
        .ds_i         (ds_i),
        .sample_o     (sample_o),
        .sample_rdy_o (sample_rdy_o),
        .sample_ack_i (sample_ack_i),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Impulse response of three cascaded length-R moving sums.
    task automatic set_r(int code);
        R = 32 << code;
        h.delete();
        for (int j = 0; j < 3 * R - 2; j++) begin
            int s = 0;
            for (int i = 0; i < 2 * R - 1; i++) begin
                if (j - i >= 0 && j - i < R)
                    s += R - ((i > R - 1) ? (i - (R - 1)) : (R - 1 - i));
            end
            h.push_back(s);
        end
    endtask

    function automatic logic [15:0] model_sample(int m);
        longint c = 0;
        longint y;
        int     n  = (m + 1) * R - 1;
        int     sh = 3 * $clog2(R) - 15;
        for (int j = 0; j < h.size(); j++) begin
            if (n - j >= 0 && n - j < xs.size())
                c += longint'(h[j]) * xs[n - j];
        end
        y = c >>> sh;
        if (y > 32767)
            y = 32767;
        else if (y < -32768)
            y = -32768;
        return 16'(y);
    endfunction

    task automatic step();
        case (mode)
            0:       ds_i = 1'b1;
            1:       ds_i = 1'b0;
            2:       ds_i = (cnt % 2 == 0);
            default: ds_i = 1'($urandom_range(0, 1));
        endcase
        if (en_i) xs.push_back(ds_i ? 1 : -1);
        @(posedge clk_i);
        if (en_i) cnt++;
        @(negedge clk_i);
        if (sample_rdy_o && !rdy_prev) begin
            int m;
            m = (cnt - SYNC - 1) / R - 1;
            check("rdy_phase", 32'((cnt - SYNC - 1) % R), 32'd0);
            check("sample", 32'(sample_o), 32'(model_sample(m)));
            if (m >= 3 && steady == 1)
                check("steady", 32'(sample_o), 32'(steady_val));
            if (m >= 3 && steady == 2)
                check("near_zero", 32'(($signed(sample_o) >= -1) && ($signed(sample_o) <= 1)), 32'd1);
        end
        rdy_prev     = sample_rdy_o;
        sample_ack_i = auto_ack && sample_rdy_o;
    endtask

    task automatic run_to(int target);
        int guard = 0;
        while (cnt < target && guard < 4000) begin
            step();
            guard++;
        end
        check("run_bound", 32'(cnt), 32'(target));
    endtask

    task automatic begin_run(int code, int md);
        set_r(code);
        xs.delete();
        cnt      = 0;
        rdy_prev = sample_rdy_o;
        osr_i    = 2'(code);
        mode     = md;
        en_i     = 1'b1;
    endtask

    task automatic do_reset();
        rst_n_i      = 1'b0;
        en_i         = 1'b0;
        sample_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        rdy_prev = 1'b0;
    endtask

    initial begin
        cnt = 0; R = 32; mode = 0; auto_ack = 1'b1; rdy_prev = 1'b0; steady = 0;
        steady_val = 16'h0000; held = 16'h0000;
        repeat (3) @(negedge clk_i);
        check("reset_sample", 32'(sample_o), 32'h0);
        check("reset_rdy", 32'(sample_rdy_o), 32'h0);
        check("reset_ovr", 32'(overrun_o), 32'h0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // R=32, constant ones, immediate ack: full scale positive.
        auto_ack = 1'b1; steady = 1; steady_val = 16'h7FFF;
        begin_run(0, 0);
        run_to(SYNC + 6 * 32 + 1);
        check("t1_ovr", 32'(overrun_o), 32'h0);

        // R=256, constant zeros: full scale negative.
        do_reset();
        steady = 1; steady_val = 16'h8000;
        begin_run(3, 1);
        run_to(SYNC + 6 * 256 + 1);
        check("t2_ovr", 32'(overrun_o), 32'h0);

        // R=64, alternating stream: mid scale.
        do_reset();
        steady = 2;
        begin_run(1, 2);
        run_to(SYNC + 6 * 64 + 1);
        check("t3_ovr", 32'(overrun_o), 32'h0);

        // R=128 random, then disable and restart R=32 random from cleared state.
        do_reset();
        steady = 0;
        begin_run(2, 3);
        run_to(SYNC + 8 * 128 + 4);
        en_i = 1'b0;
        repeat (6) step();
        check("t4_idle_rdy", 32'(sample_rdy_o), 32'h0);
        begin_run(0, 3);
        run_to(SYNC + 6 * 32 + 1);
        check("t4_ovr", 32'(overrun_o), 32'h0);

        // Ack withheld: first sample held, overrun after the second strobe.
        do_reset();
        auto_ack = 1'b0;
        begin_run(0, 3);
        run_to(SYNC + R + 1);
        held = sample_o;
        check("t5_rdy", 32'(sample_rdy_o), 32'h1);
        run_to(SYNC + 2 * R);
        check("t5_ovr_pre", 32'(overrun_o), 32'h0);
        run_to(SYNC + 2 * R + 1);
        check("t5_ovr_set", 32'(overrun_o), 32'h1);
        check("t5_held1", 32'(sample_o), 32'(held));
        run_to(SYNC + 3 * R + R / 2);
        check("t5_held2", 32'(sample_o), 32'(held));
        check("t5_rdy_held", 32'(sample_rdy_o), 32'h1);
        sample_ack_i = 1'b1;
        step();
        check("t5_rdy_clr", 32'(sample_rdy_o), 32'h0);
        run_to(SYNC + 4 * R);
        check("t5_rdy_idle", 32'(sample_rdy_o), 32'h0);
        run_to(SYNC + 4 * R + 1);
        check("t5_rdy_next", 32'(sample_rdy_o), 32'h1);
        check("t5_ovr_sticky", 32'(overrun_o), 32'h1);

        // Asynchronous reset while a sample is pending and overrun is set.
        #2;
        rst_n_i = 1'b0;
        #1;
        check("t7_rst_sample", 32'(sample_o), 32'h0);
        check("t7_rst_rdy", 32'(sample_rdy_o), 32'h0);
        check("t7_rst_ovr", 32'(overrun_o), 32'h0);
        en_i = 1'b0;
        sample_ack_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        rdy_prev = 1'b0;
        auto_ack = 1'b1;
        begin_run(1, 3);
        run_to(4);
        osr_i = 2'd3;
        run_to(SYNC + R);
        check("t7_rdy_early", 32'(sample_rdy_o), 32'h0);
        run_to(SYNC + R + 1);
        check("t7_rdy_first", 32'(sample_rdy_o), 32'h1);
        run_to(SYNC + 2 * R);
        check("t7_rdy_gap", 32'(sample_rdy_o), 32'h0);
        run_to(SYNC + 2 * R + 1);
        check("t7_rdy_second", 32'(sample_rdy_o), 32'h1);

        // Ack in the same cycle as a new sample: loads, stays ready, no overrun.
        do_reset();
        auto_ack = 1'b0;
        begin_run(0, 3);
        run_to(SYNC + 2 * R);
        check("t6_rdy_pre", 32'(sample_rdy_o), 32'h1);
        check("t6_ovr_pre", 32'(overrun_o), 32'h0);
        sample_ack_i = 1'b1;
        step();
        check("t6_rdy", 32'(sample_rdy_o), 32'h1);
        check("t6_sample", 32'(sample_o), 32'(model_sample(1)));
        check("t6_ovr", 32'(overrun_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
